// File: rtl/apply_iteration_controller.sv
// Apply-stage iteration sequencer: launches an iteration, waits for every core
// to report its iteration end, lets late vertex updates drain in, then either
// finishes the run (converged or iteration limit) or flushes the per-core
// pipelines and launches the next iteration.
module apply_iteration_controller #(
    parameter int CORE_NUM        = 32,
    parameter int ITERATION_WIDTH = 8,
    parameter int MAX_ITERATION   = 255,
    parameter int DRAIN_CYCLES    = 4,
    parameter int FLUSH_CYCLES    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CORE_NUM-1:0]        front_active_v_updated,
    input  logic [CORE_NUM-1:0]        front_active_v_valid,
    input  logic [CORE_NUM-1:0]        front_iteration_end,
    input  logic [CORE_NUM-1:0]        front_iteration_end_valid,
    output logic [CORE_NUM-1:0]        core_rst,
    output logic                       iteration_start,
    output logic [ITERATION_WIDTH-1:0] iteration_id,
    output logic                       busy,
    output logic                       done,
    output logic                       converged,
    output logic [ITERATION_WIDTH-1:0] total_iterations
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [DRAIN_W-1:0]         DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [FLUSH_W-1:0]         FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [ITERATION_WIDTH-1:0] LAST_ID    = ITERATION_WIDTH'(MAX_ITERATION - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_DRAIN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [CORE_NUM-1:0]        end_mask_q, end_mask_d;
    logic                       updated_flag_q, updated_flag_d;
    logic [DRAIN_W-1:0]         drain_cnt_q, drain_cnt_d;
    logic [FLUSH_W-1:0]         flush_cnt_q, flush_cnt_d;
    logic [ITERATION_WIDTH-1:0] iteration_id_q, iteration_id_d;
    logic [ITERATION_WIDTH-1:0] total_iterations_q, total_iterations_d;
    logic                       converged_q, converged_d;
    logic                       done_q, done_d;
    logic                       busy_q, busy_d;
    logic                       iteration_start_q, iteration_start_d;
    logic [CORE_NUM-1:0]        core_rst_q, core_rst_d;

    logic [CORE_NUM-1:0]        new_ends;
    logic                       updated_now;
    logic                       ends_complete;
    logic                       start_accept;
    logic                       drain_expired;
    logic                       flush_expired;
    logic                       at_limit;

    // Qualified per-cycle events and the decision terms shared by the FSM and datapath
    assign new_ends      = front_iteration_end & front_iteration_end_valid;
    assign updated_now   = updated_flag_q | (|(front_active_v_updated & front_active_v_valid));
    assign ends_complete = &(end_mask_q | new_ends);
    assign start_accept  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign drain_expired = (state_q == ST_DRAIN) && (drain_cnt_q == '0);
    assign flush_expired = (state_q == ST_FLUSH) && (flush_cnt_q == '0);
    assign at_limit      = (iteration_id_q == LAST_ID);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing through launch, run, drain, flush and done
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ends_complete) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_expired) begin
                    if (!updated_now || at_limit) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_expired) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_LAUNCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Per-iteration accumulation of core ends and vertex-updated results
    always_comb begin
        end_mask_d     = end_mask_q;
        updated_flag_d = updated_flag_q;
        unique case (state_q)
            ST_LAUNCH: begin
                end_mask_d     = '0;
                updated_flag_d = 1'b0;
            end
            ST_RUN: begin
                end_mask_d     = end_mask_q | new_ends;
                updated_flag_d = updated_now;
            end
            ST_DRAIN: begin
                updated_flag_d = updated_now;
            end
            default: begin
                end_mask_d     = end_mask_q;
                updated_flag_d = updated_flag_q;
            end
        endcase
    end

    // Drain and flush down-counters, loaded on entry and decremented to zero
    always_comb begin
        drain_cnt_d = drain_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q == ST_RUN) && ends_complete) begin
            drain_cnt_d = DRAIN_LOAD;
        end else if ((state_q == ST_DRAIN) && (drain_cnt_q != '0)) begin
            drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        end
        if ((state_q == ST_DRAIN) && (state_d == ST_FLUSH)) begin
            flush_cnt_d = FLUSH_LOAD;
        end else if ((state_q == ST_FLUSH) && (flush_cnt_q != '0)) begin
            flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
        end
    end

    // Iteration index and run result; results latch on the way into DONE
    always_comb begin
        iteration_id_d     = iteration_id_q;
        total_iterations_d = total_iterations_q;
        converged_d        = converged_q;
        if (start_accept) begin
            iteration_id_d = '0;
            converged_d    = 1'b0;
        end else if ((state_q == ST_FLUSH) && (state_d == ST_LAUNCH)) begin
            iteration_id_d = iteration_id_q + ITERATION_WIDTH'(1);
        end
        if ((state_q == ST_DRAIN) && (state_d == ST_DONE)) begin
            total_iterations_d = iteration_id_q + ITERATION_WIDTH'(1);
            converged_d        = !updated_now;
        end
    end

    // Output decode from the next state so every output is a plain register
    always_comb begin
        core_rst_d        = '1;
        iteration_start_d = 1'b0;
        busy_d            = 1'b0;
        done_d            = 1'b0;
        unique case (state_d)
            ST_LAUNCH: begin
                core_rst_d        = '0;
                iteration_start_d = 1'b1;
                busy_d            = 1'b1;
            end
            ST_RUN, ST_DRAIN: begin
                core_rst_d = '0;
                busy_d     = 1'b1;
            end
            ST_FLUSH: begin
                busy_d = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                core_rst_d = '1;
            end
        endcase
    end

    // Datapath and output registers; reset discards any partial run
    always_ff @(posedge clk) begin
        if (rst) begin
            end_mask_q         <= '0;
            updated_flag_q     <= 1'b0;
            drain_cnt_q        <= '0;
            flush_cnt_q        <= '0;
            iteration_id_q     <= '0;
            total_iterations_q <= '0;
            converged_q        <= 1'b0;
            done_q             <= 1'b0;
            busy_q             <= 1'b0;
            iteration_start_q  <= 1'b0;
            core_rst_q         <= '1;
        end else begin
            end_mask_q         <= end_mask_d;
            updated_flag_q     <= updated_flag_d;
            drain_cnt_q        <= drain_cnt_d;
            flush_cnt_q        <= flush_cnt_d;
            iteration_id_q     <= iteration_id_d;
            total_iterations_q <= total_iterations_d;
            converged_q        <= converged_d;
            done_q             <= done_d;
            busy_q             <= busy_d;
            iteration_start_q  <= iteration_start_d;
            core_rst_q         <= core_rst_d;
        end
    end

    assign core_rst         = core_rst_q;
    assign iteration_start  = iteration_start_q;
    assign iteration_id     = iteration_id_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign converged        = converged_q;
    assign total_iterations = total_iterations_q;

endmodule

// File: tb/tb_apply_iteration_controller.sv
// Testbench for apply_iteration_controller: each run is planned as a sequence
// of iterations (no update / update somewhere / update only in the last drain
// cycle); the expected cycle-by-cycle timeline is built from the phase lengths
// and compared against what the controller produces.
module tb_apply_iteration_controller;

    localparam int CN   = 4;
    localparam int IW   = 8;
    localparam int MAXI = 3;
    localparam int DR   = 4;
    localparam int FL   = 2;
    localparam int MAXC = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CN-1:0] upd, updv, endf, endv;
    logic [CN-1:0] core_rst;
    logic          iteration_start;
    logic [IW-1:0] iteration_id;
    logic          busy, done, converged;
    logic [IW-1:0] total_iterations;

    int checks   = 0;
    int failures = 0;

    // Planned stimulus and expected timeline, indexed by cycle from the start request
    logic          s_start [MAXC];
    logic [CN-1:0] s_end   [MAXC];
    logic [CN-1:0] s_endv  [MAXC];
    logic [CN-1:0] s_upd   [MAXC];
    logic [CN-1:0] s_updv  [MAXC];
    logic          e_start [MAXC];
    logic          e_busy  [MAXC];
    logic          e_done  [MAXC];
    logic          e_crst  [MAXC];
    logic [IW-1:0] e_id    [MAXC];
    logic          a_start [MAXC];
    logic          a_busy  [MAXC];
    logic          a_done  [MAXC];
    logic          a_conv  [MAXC];
    logic [CN-1:0] a_crst  [MAXC];
    logic [IW-1:0] a_id    [MAXC];
    logic [IW-1:0] a_total [MAXC];
    int            plan_kind [8];
    int            sched_len;
    logic          exp_conv;
    logic [IW-1:0] exp_total;

    apply_iteration_controller #(
        .CORE_NUM(CN), .ITERATION_WIDTH(IW), .MAX_ITERATION(MAXI),
        .DRAIN_CYCLES(DR), .FLUSH_CYCLES(FL)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .front_active_v_updated(upd), .front_active_v_valid(updv),
        .front_iteration_end(endf), .front_iteration_end_valid(endv),
        .core_rst(core_rst), .iteration_start(iteration_start),
        .iteration_id(iteration_id), .busy(busy), .done(done),
        .converged(converged), .total_iterations(total_iterations)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 1'b0;
        upd   = '0;
        updv  = '0;
        endf  = '0;
        endv  = '0;
    endtask

    // Build the expected timeline: launch 1 cycle, run until the last valid end,
    // DR drain cycles, then done or FL flush cycles before the next launch
    task automatic build_schedule();
        int   c, k, maxe, upd_at, b;
        int   end_at [CN];
        logic fin;
        for (int i = 0; i < MAXC; i++) begin
            s_start[i] = 1'b0; s_end[i] = '0; s_endv[i] = '0; s_upd[i] = '0; s_updv[i] = '0;
            e_start[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0; e_crst[i] = 1'b1; e_id[i] = '0;
        end
        s_start[0] = 1'b1;
        c   = 1;
        k   = 0;
        fin = 1'b0;
        while (!fin) begin
            e_start[c] = 1'b1; e_busy[c] = 1'b1; e_crst[c] = 1'b0; e_id[c] = IW'(k);
            s_end[c] = '1; s_endv[c] = '1; s_upd[c] = '1; s_updv[c] = '1; s_start[c] = 1'b1;
            c++;
            maxe = 0;
            for (int i = 0; i < CN; i++) begin
                end_at[i] = $urandom_range(0, 5);
                if (end_at[i] > maxe) maxe = end_at[i];
            end
            upd_at = -1;
            if (plan_kind[k] == 1) upd_at = $urandom_range(0, maxe + DR - 1);
            else if (plan_kind[k] == 2) upd_at = maxe + DR;
            for (int j = 0; j <= maxe + DR; j++) begin
                e_busy[c] = 1'b1; e_crst[c] = 1'b0; e_id[c] = IW'(k);
                for (int i = 0; i < CN; i++) begin
                    if (j == end_at[i]) begin
                        s_end[c][i] = 1'b1; s_endv[c][i] = 1'b1;
                    end else if (j < end_at[i]) begin
                        b = $urandom_range(0, 2);
                        s_end[c][i]  = (b == 1);
                        s_endv[c][i] = (b == 2);
                    end else begin
                        s_end[c][i]  = 1'($urandom);
                        s_endv[c][i] = 1'($urandom);
                    end
                end
                s_upd[c]  = CN'($urandom);
                s_updv[c] = CN'($urandom) & ~s_upd[c];
                if (j == upd_at) begin
                    b = $urandom_range(0, CN - 1);
                    s_upd[c][b]  = 1'b1;
                    s_updv[c][b] = 1'b1;
                end
                s_start[c] = ($urandom_range(0, 3) == 0);
                c++;
            end
            if (plan_kind[k] == 0 || k == MAXI - 1) begin
                fin       = 1'b1;
                exp_conv  = (plan_kind[k] == 0);
                exp_total = IW'(k + 1);
            end else begin
                for (int j = 0; j < FL; j++) begin
                    e_busy[c] = 1'b1; e_crst[c] = 1'b1; e_id[c] = IW'(k);
                    s_end[c] = CN'($urandom); s_endv[c] = '1;
                    s_upd[c] = '1; s_updv[c] = CN'($urandom);
                    s_start[c] = ($urandom_range(0, 1) == 0);
                    c++;
                end
                k++;
            end
        end
        for (int j = 0; j < 3; j++) begin
            e_done[c] = 1'b1; e_crst[c] = 1'b1; e_id[c] = IW'(k);
            s_end[c] = CN'($urandom); s_endv[c] = CN'($urandom);
            s_upd[c] = CN'($urandom); s_updv[c] = CN'($urandom);
            c++;
        end
        sched_len = c;
    endtask

    // Replay the planned stimulus and record the outputs seen in each cycle
    task automatic play_schedule();
        for (int c = 0; c < sched_len; c++) begin
            step();
            a_start[c] = iteration_start; a_busy[c] = busy; a_done[c] = done;
            a_conv[c]  = converged; a_crst[c] = core_rst; a_id[c] = iteration_id;
            a_total[c] = total_iterations;
            start = s_start[c]; endf = s_end[c]; endv = s_endv[c];
            upd   = s_upd[c];   updv = s_updv[c];
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1; upd = '1; updv = '1; endf = '1; endv = '1;
        step();
        step();
        rst = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            upd = CN'($urandom); updv = CN'($urandom); endf = CN'($urandom); endv = CN'($urandom);
            checks++;
            if (core_rst !== 4'hF) begin failures++; $display("[TB] FAIL reset.core_rst got=%h exp=f", core_rst); end
            checks++;
            if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset.busy got=%b exp=0", busy); end
            checks++;
            if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset.done got=%b exp=0", done); end
            checks++;
            if (iteration_start !== 1'b0) begin failures++; $display("[TB] FAIL reset.iteration_start got=%b exp=0", iteration_start); end
            checks++;
            if (iteration_id !== '0 || converged !== 1'b0 || total_iterations !== '0) begin
                failures++;
                $display("[TB] FAIL reset.results id=%0d conv=%b total=%0d exp=0/0/0", iteration_id, converged, total_iterations);
            end
        end
        clear_inputs();
    endtask

    task automatic test_single_iteration();
        logic [CN-1:0] exp_cr;
        plan_kind[0] = 0;
        build_schedule();
        play_schedule();
        for (int c = 1; c < sched_len; c++) begin
            exp_cr = e_crst[c] ? '1 : '0;
            checks++;
            if (a_start[c] !== e_start[c] || a_busy[c] !== e_busy[c] || a_done[c] !== e_done[c]) begin
                failures++;
                $display("[TB] FAIL single.ctrl cycle=%0d got start/busy/done=%b%b%b exp=%b%b%b",
                         c, a_start[c], a_busy[c], a_done[c], e_start[c], e_busy[c], e_done[c]);
            end
            checks++;
            if (a_crst[c] !== exp_cr || a_id[c] !== e_id[c]) begin
                failures++;
                $display("[TB] FAIL single.rst_id cycle=%0d got core_rst=%h id=%0d exp=%h id=%0d",
                         c, a_crst[c], a_id[c], exp_cr, e_id[c]);
            end
            if (e_done[c]) begin
                checks++;
                if (a_conv[c] !== exp_conv || a_total[c] !== exp_total) begin
                    failures++;
                    $display("[TB] FAIL single.result cycle=%0d got conv=%b total=%0d exp conv=%b total=%0d",
                             c, a_conv[c], a_total[c], exp_conv, exp_total);
                end
            end
        end
    endtask

    task automatic test_multi_iteration();
        logic [CN-1:0] exp_cr;
        plan_kind[0] = 1; plan_kind[1] = 1; plan_kind[2] = 0;
        build_schedule();
        play_schedule();
        for (int c = 1; c < sched_len; c++) begin
            exp_cr = e_crst[c] ? '1 : '0;
            checks++;
            if (a_start[c] !== e_start[c] || a_busy[c] !== e_busy[c] || a_done[c] !== e_done[c]) begin
                failures++;
                $display("[TB] FAIL multi.ctrl cycle=%0d got start/busy/done=%b%b%b exp=%b%b%b",
                         c, a_start[c], a_busy[c], a_done[c], e_start[c], e_busy[c], e_done[c]);
            end
            checks++;
            if (a_crst[c] !== exp_cr || a_id[c] !== e_id[c]) begin
                failures++;
                $display("[TB] FAIL multi.rst_id cycle=%0d got core_rst=%h id=%0d exp=%h id=%0d",
                         c, a_crst[c], a_id[c], exp_cr, e_id[c]);
            end
            if (e_done[c]) begin
                checks++;
                if (a_conv[c] !== exp_conv || a_total[c] !== exp_total) begin
                    failures++;
                    $display("[TB] FAIL multi.result cycle=%0d got conv=%b total=%0d exp conv=%b total=%0d",
                             c, a_conv[c], a_total[c], exp_conv, exp_total);
                end
            end
        end
    endtask

    task automatic test_iteration_limit();
        logic [CN-1:0] exp_cr;
        plan_kind[0] = 1; plan_kind[1] = 1; plan_kind[2] = 1;
        build_schedule();
        play_schedule();
        for (int c = 1; c < sched_len; c++) begin
            exp_cr = e_crst[c] ? '1 : '0;
            checks++;
            if (a_start[c] !== e_start[c] || a_busy[c] !== e_busy[c] || a_done[c] !== e_done[c]) begin
                failures++;
                $display("[TB] FAIL limit.ctrl cycle=%0d got start/busy/done=%b%b%b exp=%b%b%b",
                         c, a_start[c], a_busy[c], a_done[c], e_start[c], e_busy[c], e_done[c]);
            end
            checks++;
            if (a_crst[c] !== exp_cr || a_id[c] !== e_id[c]) begin
                failures++;
                $display("[TB] FAIL limit.rst_id cycle=%0d got core_rst=%h id=%0d exp=%h id=%0d",
                         c, a_crst[c], a_id[c], exp_cr, e_id[c]);
            end
            if (e_done[c]) begin
                checks++;
                if (a_conv[c] !== exp_conv || a_total[c] !== exp_total) begin
                    failures++;
                    $display("[TB] FAIL limit.result cycle=%0d got conv=%b total=%0d exp conv=%b total=%0d",
                             c, a_conv[c], a_total[c], exp_conv, exp_total);
                end
            end
        end
    endtask

    // Runs straight after a finished run, so this also covers restart from DONE
    task automatic test_late_update();
        logic [CN-1:0] exp_cr;
        plan_kind[0] = 2; plan_kind[1] = 0;
        build_schedule();
        play_schedule();
        for (int c = 1; c < sched_len; c++) begin
            exp_cr = e_crst[c] ? '1 : '0;
            checks++;
            if (a_start[c] !== e_start[c] || a_busy[c] !== e_busy[c] || a_done[c] !== e_done[c]) begin
                failures++;
                $display("[TB] FAIL late.ctrl cycle=%0d got start/busy/done=%b%b%b exp=%b%b%b",
                         c, a_start[c], a_busy[c], a_done[c], e_start[c], e_busy[c], e_done[c]);
            end
            checks++;
            if (a_crst[c] !== exp_cr || a_id[c] !== e_id[c]) begin
                failures++;
                $display("[TB] FAIL late.rst_id cycle=%0d got core_rst=%h id=%0d exp=%h id=%0d",
                         c, a_crst[c], a_id[c], exp_cr, e_id[c]);
            end
            if (e_done[c]) begin
                checks++;
                if (a_conv[c] !== exp_conv || a_total[c] !== exp_total) begin
                    failures++;
                    $display("[TB] FAIL late.result cycle=%0d got conv=%b total=%0d exp conv=%b total=%0d",
                             c, a_conv[c], a_total[c], exp_conv, exp_total);
                end
            end
        end
    endtask

    // Abort a run in progress, then confirm a fresh run still works from IDLE
    task automatic test_mid_run_reset();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1; start = 1'b1; endf = '1; endv = '1;
        step();
        rst = 1'b0;
        clear_inputs();
        checks++;
        if (core_rst !== 4'hF || busy !== 1'b0 || done !== 1'b0 || iteration_start !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort.ctrl got core_rst=%h busy=%b done=%b start=%b exp f/0/0/0",
                     core_rst, busy, done, iteration_start);
        end
        checks++;
        if (iteration_id !== '0 || converged !== 1'b0 || total_iterations !== '0) begin
            failures++;
            $display("[TB] FAIL abort.results got id=%0d conv=%b total=%0d exp 0/0/0",
                     iteration_id, converged, total_iterations);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (busy !== 1'b0 || iteration_start !== 1'b0 || core_rst !== 4'hF) begin
                failures++;
                $display("[TB] FAIL abort.idle got busy=%b start=%b core_rst=%h exp 0/0/f",
                         busy, iteration_start, core_rst);
            end
        end
        plan_kind[0] = 1; plan_kind[1] = 0;
        build_schedule();
        play_schedule();
        checks++;
        if (a_start[1] !== 1'b1 || a_id[1] !== '0) begin
            failures++;
            $display("[TB] FAIL abort.relaunch got start=%b id=%0d exp 1/0", a_start[1], a_id[1]);
        end
        checks++;
        if (a_done[sched_len-1] !== 1'b1 || a_conv[sched_len-1] !== 1'b1 || a_total[sched_len-1] !== 8'd2) begin
            failures++;
            $display("[TB] FAIL abort.rerun got done=%b conv=%b total=%0d exp 1/1/2",
                     a_done[sched_len-1], a_conv[sched_len-1], a_total[sched_len-1]);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_iteration();
        test_multi_iteration();
        test_iteration_limit();
        test_late_update();
        test_mid_run_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
